// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and parity mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-phase counter for the UART receiver: counts clk cycles within one bit period
// and flags the half-bit point (start validation) and the full-bit point (bit sampling).
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic mid_tick_o,
  output logic bit_tick_o
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] MID_PHASE  = PW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(CLKS_PER_BIT - 1);

  logic [PW-1:0] phase_q, phase_d;

  // Next phase: clear has priority, otherwise count and roll over at the end of the bit.
  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign mid_tick_o = (phase_q == MID_PHASE);
  assign bit_tick_o = (phase_q == LAST_PHASE);

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: synchronises rx, validates the start bit at half-bit, samples
// data/parity/stop bits at the bit centre and hands each frame out on a valid/ready port.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 9,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 en,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD_P     = (PARITY == PARITY_ODD);

  if (DATA_BITS < 1 || DATA_BITS > 16 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      LSB_FIRST < 0 || LSB_FIRST > 1) begin : g_param_check
    $error("uart_frame_rx: illegal parameter combination");
  end

  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic start_edge, mid_tick, bit_tick, timer_clr, timer_en;
  logic deliver;

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, shifted;
  logic [DATA_BITS:0]   ext;
  logic                 par_acc_q, par_acc_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  // Two-flop synchroniser plus previous-sample flop for falling-edge detection; idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_s_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .mid_tick_o(mid_tick),
    .bit_tick_o(bit_tick)
  );

  // Shift the synchronised bit into the data word from the end given by LSB_FIRST.
  always_comb begin
    ext     = '0;
    shifted = shift_q;
    if (LSB_FIRST != 0) begin
      ext     = {rx_s_q, shift_q};
      shifted = ext[DATA_BITS:1];
    end else begin
      ext     = {shift_q, rx_s_q};
      shifted = ext[DATA_BITS-1:0];
    end
  end

  // Frame FSM, bit sampling and output port handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = (state_q != S_IDLE);
    deliver      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge && en) begin
          state_d   = S_START;
          timer_clr = 1'b1;
        end
      end
      S_START: begin
        if (mid_tick) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            // Phase restarts at the start-bit centre so bit_tick lands mid-bit from now on.
            state_d   = S_DATA;
            timer_clr = 1'b1;
            cnt_d     = '0;
            par_acc_d = 1'b0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d   = shifted;
          par_acc_d = par_acc_q ^ rx_s_q;
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          perr_d  = par_acc_q ^ rx_s_q ^ ODD_P;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          ferr_d = ferr_q | ~rx_s_q;
          if (cnt_q == LAST_STOP) begin
            // Back to IDLE immediately so a start edge late in the stop bit is not missed.
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      if (!valid_q || ready) begin
        data_d       = shift_q;
        frame_err_d  = ferr_q | ~rx_s_q;
        parity_err_d = perr_q;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: instance A uses the default 9N1 format, instance B is 8E1.
module tb_uart_frame_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, en_a, ready_a, valid_a, frame_err_a, parity_err_a, overrun_a, busy_a;
  logic [8:0] data_a;
  logic       rx_b, en_b, ready_b, valid_b, frame_err_b, parity_err_b, overrun_b, busy_b;
  logic [7:0] data_b;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .DATA_BITS(9), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .en(en_a), .data(data_a), .valid(valid_a),
    .ready(ready_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
    .overrun(overrun_a), .busy(busy_a)
  );

  uart_frame_rx #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .en(en_b), .data(data_b), .valid(valid_b),
    .ready(ready_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
    .overrun(overrun_b), .busy(busy_b)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          hs_a = 0, hs_b = 0, ovr_a = 0, ovr_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic pe, input logic fe, input logic [15:0] d);
    return {14'd0, pe, fe, d};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare on every handshake; count overrun cycles.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      hs_a++;
      check_eq("rxA_pending", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0)
        check_eq("rxA_frame", pack(parity_err_a, frame_err_a, 16'(data_a)), qa.pop_front());
    end
    if (valid_b && ready_b) begin
      hs_b++;
      check_eq("rxB_pending", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0)
        check_eq("rxB_frame", pack(parity_err_b, frame_err_b, 16'(data_b)), qb.pop_front());
    end
    if (overrun_a) ovr_a++;
    if (overrun_b) ovr_b++;
  end

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v);
    set_rx(sel, v);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input int nbits, input logic [15:0] d,
                      input bit use_par, input logic par, input logic stp);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    hold_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(sel, d[i]);
    if (use_par) hold_bit(sel, par);
    hold_bit(sel, stp);
    hold_bit(sel, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int hs0;
    int ov0;
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    en_a = 1'b1; en_b = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_data", 32'(data_a), 32'd0);
    check_eq("rst_flags", 32'({frame_err_a, parity_err_a, overrun_a}), 32'd0);
    check_eq("rst_valid_b", 32'(valid_b), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 1: basic frame, latency, single-cycle valid with ready=1
    qa.push_back(pack(1'b0, 1'b0, 16'h155));
    fork
      send(1'b0, 9, 16'h155, 1'b0, 1'b0, 1'b1);
      begin
        for (int k = 0; k < 400 && !valid_a; k++) @(negedge clk);
        check_eq("t1_valid", 32'(valid_a), 32'd1);
        check_eq("t1_latency", 32'(cyc - start_cyc), 32'd171);
        check_eq("t1_busy_low", 32'(busy_a), 32'd0);
        @(negedge clk);
        check_eq("t1_valid_1cyc", 32'(valid_a), 32'd0);
      end
    join

    // 2: false start, then a good frame
    hs0 = hs_a;
    @(posedge clk);
    #1;
    set_rx(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    set_rx(1'b0, 1'b1);
    check_eq("t2_busy_hi", 32'(busy_a), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check_eq("t2_busy_lo", 32'(busy_a), 32'd0);
    hold_bit(1'b0, 1'b1);
    check_eq("t2_no_frame", 32'(hs_a), 32'(hs0));
    qa.push_back(pack(1'b0, 1'b0, 16'h0AA));
    send(1'b0, 9, 16'h0AA, 1'b0, 1'b0, 1'b1);

    // 3: stop bit 0, then a break
    qa.push_back(pack(1'b0, 1'b1, 16'h0F0));
    send(1'b0, 9, 16'h0F0, 1'b0, 1'b0, 1'b0);
    qa.push_back(pack(1'b0, 1'b1, 16'h000));
    @(posedge clk);
    #1;
    set_rx(1'b0, 1'b0);
    repeat (12 * CPB) @(posedge clk);
    #1;
    hold_bit(1'b0, 1'b1);
    hold_bit(1'b0, 1'b1);

    // 4: even parity on instance B
    qb.push_back(pack(1'b1, 1'b0, 16'h00A5));
    send(1'b1, 8, 16'h00A5, 1'b1, 1'b1, 1'b1);
    qb.push_back(pack(1'b0, 1'b0, 16'h00A5));
    send(1'b1, 8, 16'h00A5, 1'b1, 1'b0, 1'b1);
    qb.push_back(pack(1'b0, 1'b0, 16'h0007));
    send(1'b1, 8, 16'h0007, 1'b1, 1'b1, 1'b1);

    // 5: overrun with ready low
    ready_a = 1'b0;
    ov0 = ovr_a;
    qa.push_back(pack(1'b0, 1'b0, 16'h011));
    send(1'b0, 9, 16'h011, 1'b0, 1'b0, 1'b1);
    send(1'b0, 9, 16'h022, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("t5_valid_held", 32'(valid_a), 32'd1);
    check_eq("t5_data_kept", 32'(data_a), 32'h011);
    check_eq("t5_overrun_once", 32'(ovr_a - ov0), 32'd1);
    @(posedge clk);
    #1;
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t5_valid_drop", 32'(valid_a), 32'd0);

    // 6: reset mid-frame, recovery, and en=0 ignoring a start edge
    ready_a = 1'b0;
    send(1'b0, 9, 16'h1C7, 1'b0, 1'b0, 1'b1);
    ov0 = ovr_a;
    @(posedge clk);
    #1;
    hold_bit(1'b0, 1'b0);
    hold_bit(1'b0, 1'b1);
    hold_bit(1'b0, 1'b0);
    hold_bit(1'b0, 1'b1);
    check_eq("t6_pre_busy", 32'(busy_a), 32'd1);
    check_eq("t6_pre_valid", 32'(valid_a), 32'd1);
    rst_n = 1'b0;
    set_rx(1'b0, 1'b1);
    @(negedge clk);
    check_eq("t6_rst_valid", 32'(valid_a), 32'd0);
    check_eq("t6_rst_busy", 32'(busy_a), 32'd0);
    check_eq("t6_rst_data", 32'(data_a), 32'd0);
    check_eq("t6_rst_flags", 32'({frame_err_a, parity_err_a, overrun_a}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_a = 1'b1;
    hold_bit(1'b0, 1'b1);
    check_eq("t6_no_overrun", 32'(ovr_a - ov0), 32'd0);
    qa.push_back(pack(1'b0, 1'b0, 16'h03C));
    send(1'b0, 9, 16'h03C, 1'b0, 1'b0, 1'b1);

    hs0 = hs_a;
    en_a = 1'b0;
    fork
      send(1'b0, 9, 16'h0F3, 1'b0, 1'b0, 1'b1);
      begin
        repeat (40) @(negedge clk);
        check_eq("t6_en0_busy", 32'(busy_a), 32'd0);
      end
    join
    en_a = 1'b1;
    check_eq("t6_en0_no_frame", 32'(hs_a), 32'(hs0));

    repeat (4) @(posedge clk);
    check_eq("end_qa_empty", 32'(qa.size()), 32'd0);
    check_eq("end_qb_empty", 32'(qb.size()), 32'd0);
    check_eq("end_ovr_b", 32'(ovr_b), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
